// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: valid/ready elastic buffer built on a circular buffer.
// Holds up to DEPTH entries and releases them in push order. flush_i drops
// every held entry at the next edge. The synchronous rst does the same and
// wins over everything else.
// Optional build macro ELASTIC_PIPE_BYPASS_EN adds a zero-latency path from
// input to output while the buffer is empty. When this macro is undefined,
// the minimum input-to-output latency is one cycle.
module elastic_pipe_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [WIDTH-1:0]        in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic push;
    logic pop;
    logic byp_pass;
    logic wr_en;
    logic rd_en;

    // Status, handshake and head-of-queue outputs
    always_comb begin
        count_o    = count_q;
        full_o     = (count_q == CNT_W'(DEPTH));
        empty_o    = (count_q == CNT_W'(0));
        in_ready_o = !full_o && !flush_i;
`ifdef ELASTIC_PIPE_BYPASS_EN
        // An empty buffer forwards the offered input straight to the output.
        if (empty_o && in_valid_i && !flush_i) begin
            out_valid_o = 1'b1;
            out_data_o  = in_data_i;
        end else begin
            out_valid_o = !empty_o && !flush_i;
            out_data_o  = mem_q[rd_ptr_q];
        end
        byp_pass = empty_o && in_valid_i && !flush_i && out_ready_i;
`else
        out_valid_o = !empty_o && !flush_i;
        out_data_o  = mem_q[rd_ptr_q];
        byp_pass    = 1'b0;
`endif
    end

    // Handshake qualification; a bypassed beat touches neither pointer
    always_comb begin
        push  = in_valid_i && in_ready_o && !flush_i;
        pop   = out_valid_o && out_ready_i && !flush_i;
        wr_en = push && !byp_pass;
        rd_en = pop && !byp_pass;
    end

    // Next-state for pointers and occupancy; flush overrides push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are qualified by count, so no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench for elastic_pipe_reg. It runs a DEPTH=2 and a DEPTH=4
// instance. Stimulus enqueues the expected payloads, and per-instance
// monitors pop them whenever a real output transfer occurs.
module tb_elastic_pipe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic        a_full, a_empty;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_full, b_empty;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_count;

    int errors = 0;
    int checks = 0;
    int b_max_cnt = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    elastic_pipe_reg #(.WIDTH(32), .DEPTH(2)) u_a (
        .clk(clk), .rst(a_rst), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .count_o(a_count), .full_o(a_full), .empty_o(a_empty)
    );

    elastic_pipe_reg #(.WIDTH(32), .DEPTH(4)) u_b (
        .clk(clk), .rst(b_rst), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .count_o(b_count), .full_o(b_full), .empty_o(b_empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor for instance A: one scoreboard pop per real transfer
    task automatic mon_a();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (a_out_valid && a_out_ready && !a_rst && !a_flush) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_out: got 0x%0h expected none", a_out_data);
                end else begin
                    e = qa.pop_front();
                    chk("a_out_data", a_out_data, e);
                end
            end
        end
    endtask

    // Output monitor for instance B; also records peak occupancy
    task automatic mon_b();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (int'(b_count) > b_max_cnt) b_max_cnt = int'(b_count);
            if (b_out_valid && b_out_ready && !b_rst && !b_flush) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_out: got 0x%0h expected none", b_out_data);
                end else begin
                    e = qb.pop_front();
                    chk("b_out_data", b_out_data, e);
                end
            end
        end
    endtask

    // Offer d on A until accepted; in_valid is left high for the caller
    task automatic push_a(input logic [31:0] d, input bit enq);
        bit ok;
        ok = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        if (enq) qa.push_back(d);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = a_in_ready;
            tick();
        end
        chk("a_push_accept", 32'(ok), 32'd1);
    endtask

    // Offer d on B until accepted; optionally toggle out_ready every cycle
    task automatic push_b(input logic [31:0] d, input bit enq, input bit tog);
        bit ok;
        ok = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        if (enq) qb.push_back(d);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = b_in_ready;
            tick();
            if (tog) b_out_ready = ~b_out_ready;
        end
        chk("b_push_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain_a();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 40 && qa.size() != 0; i++) @(posedge clk);
        #1;
        chk("a_drain_left", 32'(qa.size()), 32'd0);
        qa.delete();
        @(negedge clk);
        chk("a_empty_after_drain", 32'(a_empty), 32'd1);
        a_out_ready = 1'b0;
    endtask

    task automatic drain_b();
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 60 && qb.size() != 0; i++) @(posedge clk);
        #1;
        chk("b_drain_left", 32'(qb.size()), 32'd0);
        qb.delete();
        @(negedge clk);
        chk("b_empty_after_drain", 32'(b_empty), 32'd1);
        b_out_ready = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        fork
            mon_a();
            mon_b();
        join_none
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Post-reset state
        @(negedge clk);
        chk("a_rst_count", 32'(a_count), 32'd0);
        chk("a_rst_empty", 32'(a_empty), 32'd1);
        chk("a_rst_full", 32'(a_full), 32'd0);
        chk("a_rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("a_rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("b_rst_count", 32'(b_count), 32'd0);
        chk("b_rst_in_ready", 32'(b_in_ready), 32'd1);
        tick();

        // DEPTH=2 fill, blocked third entry, then ordered drain
        push_a(32'hA1, 1'b1);
        push_a(32'hA2, 1'b1);
        a_in_data = 32'hA3;
        qa.push_back(32'hA3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("a_full_count", 32'(a_count), 32'd2);
            chk("a_full_flag", 32'(a_full), 32'd1);
            chk("a_full_in_ready", 32'(a_in_ready), 32'd0);
            chk("a_full_head", a_out_data, 32'hA1);
            tick();
        end
        a_out_ready = 1'b1;
        push_a(32'hA3, 1'b0);
        drain_a();
        tick();

        // Simultaneous push and pop at one held entry
        a_out_ready = 1'b1;
        push_a(32'h11, 1'b1);
        push_a(32'h22, 1'b1);
        a_in_valid = 1'b0;
        @(negedge clk);
`ifdef ELASTIC_PIPE_BYPASS_EN
        chk("a_pushpop_count", 32'(a_count), 32'd0);
`else
        chk("a_pushpop_count", 32'(a_count), 32'd1);
`endif
        drain_a();
        tick();

        // Reset with two held entries and concurrent push/pop
        push_a(32'hB1, 1'b1);
        push_a(32'hB2, 1'b1);
        a_rst       = 1'b1;
        a_in_data   = 32'hB3;
        a_out_ready = 1'b1;
        qa.delete();
        tick();
        a_rst       = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        @(negedge clk);
        chk("a_rst_mid_count", 32'(a_count), 32'd0);
        chk("a_rst_mid_out_valid", 32'(a_out_valid), 32'd0);
        chk("a_rst_mid_in_ready", 32'(a_in_ready), 32'd1);
        chk("a_rst_mid_empty", 32'(a_empty), 32'd1);
        tick();

        // DEPTH=4 streaming 0..9 with out_ready toggling every cycle
        b_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_b(32'(i), 1'b1, 1'b1);
        drain_b();
        chk("b_max_count", 32'(b_max_cnt), 32'd4);
        tick();

        // Head payload holds for five stalled cycles while pushes continue
        push_b(32'h1234, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                b_in_valid = 1'b1;
                b_in_data  = 32'h2001 + 32'(k);
                qb.push_back(b_in_data);
            end else begin
                b_in_valid = 1'b0;
            end
            @(negedge clk);
            chk("b_stall_valid", 32'(b_out_valid), 32'd1);
            chk("b_stall_data", b_out_data, 32'h1234);
            tick();
        end
        chk("b_stall_count", 32'(b_count), 32'd4);
        drain_b();
        tick();

        // Flush at three held entries discards the offered 0x55
        push_b(32'hC1, 1'b1, 1'b0);
        push_b(32'hC2, 1'b1, 1'b0);
        push_b(32'hC3, 1'b1, 1'b0);
        b_flush   = 1'b1;
        b_in_data = 32'h55;
        qb.delete();
        @(negedge clk);
        chk("b_flush_out_valid", 32'(b_out_valid), 32'd0);
        chk("b_flush_in_ready", 32'(b_in_ready), 32'd0);
        tick();
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_post_flush_count", 32'(b_count), 32'd0);
        chk("b_post_flush_empty", 32'(b_empty), 32'd1);
        chk("b_post_flush_out_valid", 32'(b_out_valid), 32'd0);
        tick();
        push_b(32'h66, 1'b1, 1'b0);
        drain_b();
        tick();

        // Empty buffer, offer with downstream ready: latency depends on build
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 32'hDEADBEEF;
        qb.push_back(32'hDEADBEEF);
        @(negedge clk);
`ifdef ELASTIC_PIPE_BYPASS_EN
        chk("b_byp_same_valid", 32'(b_out_valid), 32'd1);
        chk("b_byp_same_data", b_out_data, 32'hDEADBEEF);
`else
        chk("b_nobyp_same_valid", 32'(b_out_valid), 32'd0);
`endif
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
`ifdef ELASTIC_PIPE_BYPASS_EN
        chk("b_byp_next_count", 32'(b_count), 32'd0);
        chk("b_byp_next_valid", 32'(b_out_valid), 32'd0);
`else
        chk("b_nobyp_next_count", 32'(b_count), 32'd1);
        chk("b_nobyp_next_valid", 32'(b_out_valid), 32'd1);
        chk("b_nobyp_next_data", b_out_data, 32'hDEADBEEF);
`endif
        drain_b();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_reg.md
ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..128).
REQ-002 SHALL have parameter DEPTH, default 2, number of storage entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush_i  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid_i  input  1  upstream offers in_data_i.
REQ-007 SHALL have port in_ready_o  output  1  block can accept an entry this cycle.
REQ-008 SHALL have port in_data_i  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid_o  output  1  out_data_o holds a valid entry.
REQ-010 SHALL have port out_ready_i  input  1  downstream consumes when high with out_valid_o.
REQ-011 SHALL have port out_data_o  output  WIDTH  head-entry payload.
REQ-012 SHALL have port count_o  output  $clog2(DEPTH)+1  number of held entries.
REQ-013 SHALL have ports full_o, empty_o  output  1 each  count_o==DEPTH, count_o==0.

Function
REQ-014 Push SHALL occur when in_valid_i && in_ready_o && !flush_i; pop when out_valid_o && out_ready_i && !flush_i.
REQ-015 in_ready_o SHALL equal !full_o && !flush_i (combinational; no same-cycle pass-through when full, even if out_ready_i=1).
REQ-016 Storage SHALL be a circular buffer: write pointer and read pointer of $clog2(DEPTH) bits, each incremented on push/pop and wrapping DEPTH-1 -> 0.
REQ-017 count_o SHALL be +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or neither.
REQ-018 Without bypass (REQ-027), out_valid_o SHALL equal !empty_o && !flush_i and out_data_o SHALL be the entry at the read pointer; minimum latency in->out 1 cycle.
REQ-019 Simultaneous push and pop at count_o==1 SHALL present the new entry on the next cycle with count_o staying 1.
REQ-020 Entries SHALL leave in push order; no entry SHALL be duplicated or dropped except by flush_i or rst.
REQ-021 flush_i=1 SHALL, at the next edge, set both pointers and count_o to 0; the in_data_i offered in the flush cycle SHALL be discarded; out_valid_o SHALL be 0 during the flush cycle.
REQ-022 flush_i SHALL take priority over push and pop in the same cycle.
REQ-023 out_data_o SHALL be stable while out_valid_o=1 and out_ready_i=0 (hold under downstream stall).
REQ-024 Storage array contents SHALL not require reset; only pointers and count SHALL be reset.

Reset
REQ-025 rst=1 at a rising edge SHALL set pointers=0, count_o=0; following outputs: in_ready_o=1, out_valid_o=0, empty_o=1, full_o=0; out_data_o don't-care.
REQ-026 rst asserted mid-transfer SHALL discard all entries identically to flush_i, with priority over flush_i, push and pop.

Configuration
REQ-027 Macro ELASTIC_PIPE_BYPASS_EN defined: when empty_o=1 and in_valid_i=1 and !flush_i, out_valid_o SHALL be 1 and out_data_o SHALL equal in_data_i combinationally; if out_ready_i=1 the entry SHALL pass without being stored (count_o stays 0); otherwise it SHALL be stored. Zero-cycle latency.
REQ-028 Macro ELASTIC_PIPE_BYPASS_EN undefined: no combinational in->out path; REQ-018 latency applies.

Verification
REQ-029 DEPTH=2, push 0xA1, 0xA2 with out_ready_i=0 -> count_o=2, full_o=1, in_ready_o=0; 0xA3 held on input not accepted; then out_ready_i=1 -> outputs 0xA1, 0xA2, 0xA3 in order.
REQ-030 DEPTH=4, continuous push 0x00..0x09 with out_ready_i toggling every cycle -> output sequence 0x00..0x09 exactly, pointers wrap twice, count_o never exceeds 4.
REQ-031 count_o=3, flush_i=1 with in_valid_i=1 data 0x55 -> next cycle count_o=0, empty_o=1, 0x55 never appears on output.
REQ-032 count_o=2, rst=1 same cycle as push/pop -> next cycle count_o=0, out_valid_o=0, in_ready_o=1.
REQ-033 Bypass build, empty, in_valid_i=1 data 0xDEADBEEF, out_ready_i=1 -> out_valid_o=1, out_data_o=0xDEADBEEF same cycle, count_o stays 0; non-bypass build -> out_valid_o=0 that cycle, 0xDEADBEEF next cycle.
REQ-034 out_valid_o=1 data 0x1234, out_ready_i=0 for 5 cycles with pushes -> out_data_o holds 0x1234 all 5 cycles.
